pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Parametrised program-counter generator for the RV32I fetch stage; successor to the fixed 32-bit PC register.
//  Selects next PC from trap, jalr, jal, branch, stall-hold or sequential sources with fixed priority.
//  Redirect targets are computed from the redirecting instruction's own PC, not from offset-corrected fetch PC.
//  Flags misaligned targets, pulses a fetch-flush on every redirect, and optionally keeps a return-address stack.
// PARAMETERS
//  XLEN       32   PC/data width in bits
//  RESET_VEC  '0   PC value loaded at reset
//  ILEN_B     4    sequential increment in bytes; targets must be ILEN_B-aligned
//  RAS_DEPTH  4    return-address-stack entries (power of 2, >=2; used only with PC_RAS_EN)
// PORTS
//  clk        in   1     clock, rising edge
//  reset      in   1     asynchronous, active-low reset
//  stall      in   1     hold PC; no sequential advance
//  fetch_rdy  in   1     fetch stage accepts pc_o this cycle
//  trap_en    in   1     take trap
//  trap_vec   in   XLEN  trap target (mtvec)
//  jalr_en    in   1     jalr resolved
//  jalr_tgt   in   XLEN  rs1+imm from ALU
//  jal_en     in   1     jal resolved
//  br_en      in   1     conditional branch taken
//  ctl_pc     in   XLEN  PC of the redirecting jal/branch instruction
//  ctl_imm    in   XLEN  sign-extended J/B immediate
//  ras_push   in   1     push ctl_pc+ILEN_B (call)
//  ras_pop    in   1     pop (return)
//  pc_o       out  XLEN  current fetch PC
//  pc_vld_o   out  1     pc_o valid for fetch
//  flush_o    out  1     one-cycle pulse: discard in-flight fetch
//  misal_o    out  1     one-cycle pulse: misaligned redirect target
//  ras_top_o  out  XLEN  predicted return address
// BEHAVIOUR
//  Reset (async): pc_o=RESET_VEC, pc_vld_o=0, flush_o=0, misal_o=0, RAS empty, ras_top_o=0, state=S_BOOT.
//  FSM: S_BOOT -> S_RUN after 1 cycle (pc_vld_o=1 from then on). S_RUN -> S_FLUSH on any redirect.
//   S_FLUSH lasts 1 cycle, then S_RUN; in S_FLUSH pc_vld_o=0 and a new redirect re-enters S_FLUSH.
//  Priority, evaluated every cycle in S_RUN/S_FLUSH: trap > jalr > jal > br > stall > sequential.
//   trap: pc<=trap_vec. jalr: pc<=jalr_tgt & ~1. jal/br: pc<=ctl_pc+ctl_imm (mod 2^XLEN).
//   Sequential: pc<=pc+ILEN_B only when pc_vld_o && fetch_rdy && !stall; otherwise hold. Stall never decrements.
//  Redirects are taken regardless of fetch_rdy or stall; flush_o=1 in the cycle after the redirect edge.
//  Misaligned target (non-trap redirect with target % ILEN_B != 0): pc<=trap_vec, misal_o=1 next cycle, flush_o=1.
//  Trap target is not checked for alignment.
//  Wrap: pc=2^XLEN-ILEN_B advances to 0, no flag.
//  Reset asserted mid-operation: immediate return to reset values; pending flush is dropped.
// CONFIGURATION
//  PC_RAS_EN defined: RAS present. push on full overwrites the oldest entry (circular pointer).
//   Pop on empty is ignored and ras_top_o=0. push&&pop in the same cycle replaces the top.
//   ras_top_o = top entry, registered; RAS is not flushed by redirects (only by reset).
//  PC_RAS_EN undefined: no RAS storage; ras_push/ras_pop ignored; ras_top_o tied 0.
// STRUCTURE
//  Package pc_pkg: pc_state_e {S_BOOT,S_RUN,S_FLUSH}; redir_src_e {R_NONE,R_TRAP,R_JALR,R_JAL,R_BR}.
//  pc_pkg also holds the alignment-check function.
//  Sub-module pc_ras (XLEN, RAS_DEPTH): circular stack with ptr/count; instantiated only under PC_RAS_EN.
//  Top: one redirect-select mux, adder for ctl_pc+ctl_imm, FSM, output registers.
// TESTING
//  Reset release, fetch_rdy=1 -> pc_vld_o 0 then 1; pc_o 0x0,0x0,0x4,0x8.
//  stall=1 for 3 cycles at pc=0x10 -> pc_o holds 0x10; release -> 0x14.
//  fetch_rdy=0 at 0x10 -> pc_o holds 0x10; no advance until fetch_rdy returns.
//  br_en, ctl_pc=0x20, ctl_imm=0x10 -> pc_o=0x30, flush_o=1, pc_vld_o=0 one cycle.
//  jalr_tgt=0x101 -> pc_o=0x100. jal with ctl_pc=0x40, ctl_imm=0x6 -> pc_o=trap_vec, misal_o=1.
//  trap_en, jal_en and br_en in the same cycle -> pc_o=trap_vec.
//  Wrap: pc=0xFFFFFFFC, advance -> pc_o=0x0.
//  PC_RAS_EN: 5 pushes into depth 4, then 4 pops -> ras_top_o order is last-in first; 5th pop -> ras_top_o=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the RV32I fetch-stage program-counter generator.
package pc_pkg;

    localparam int unsigned MAX_XLEN = 64;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FLUSH
    } pc_state_e;

    typedef enum logic [2:0] {
        R_NONE,
        R_TRAP,
        R_JALR,
        R_JAL,
        R_BR
    } redir_src_e;

    // align_b must be a power of two
    function automatic logic is_aligned(input logic [MAX_XLEN-1:0] addr,
                                        input logic [MAX_XLEN-1:0] align_b);
        return (addr & (align_b - MAX_XLEN'(1))) == '0;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push on a full stack overwrites the oldest entry.
module pc_ras #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] top_o
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  top_q, top_d;
    logic [PTR_W-1:0] top_idx, below_idx, wr_idx;
    logic             wr_en;

    // ptr_q is the next free slot; pointer arithmetic wraps because depth is a power of two
    assign top_idx   = ptr_q - PTR_W'(1);
    assign below_idx = ptr_q - PTR_W'(2);

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        top_d  = top_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (push_i && pop_i && (cnt_q != '0)) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
            top_d  = data_i;
        end else if (push_i) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(RAS_DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            top_d = data_i;
        end else if (pop_i && (cnt_q != '0)) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CNT_W'(1);
            top_d = (cnt_q == CNT_W'(1)) ? '0 : mem_q[below_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            top_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            top_q <= top_d;
        end
    end

    // Storage needs no reset: entries are only read while cnt_q says they are live
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= data_i;
        end
    end

    assign top_o = top_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator with prioritised redirects, flush/misalign pulses.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int unsigned     ILEN_B    = 4,
    parameter int unsigned     RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            fetch_rdy,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            jalr_en,
    input  logic [XLEN-1:0] jalr_tgt,
    input  logic            jal_en,
    input  logic            br_en,
    input  logic [XLEN-1:0] ctl_pc,
    input  logic [XLEN-1:0] ctl_imm,
    input  logic            ras_push,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_vld_o,
    output logic            flush_o,
    output logic            misal_o,
    output logic [XLEN-1:0] ras_top_o
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            vld_q, vld_d;
    logic            flush_q, flush_d;
    logic            misal_q, misal_d;
    redir_src_e      src;
    logic [XLEN-1:0] ctl_tgt, redir_tgt;

    // Targets come from the redirecting instruction's own PC
    assign ctl_tgt = ctl_pc + ctl_imm;

    always_comb begin
        src       = R_NONE;
        redir_tgt = trap_vec;
        if (trap_en) begin
            src       = R_TRAP;
            redir_tgt = trap_vec;
        end else if (jalr_en) begin
            src       = R_JALR;
            redir_tgt = {jalr_tgt[XLEN-1:1], 1'b0};
        end else if (jal_en) begin
            src       = R_JAL;
            redir_tgt = ctl_tgt;
        end else if (br_en) begin
            src       = R_BR;
            redir_tgt = ctl_tgt;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = 1'b0;
        misal_d = 1'b0;
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN, S_FLUSH: begin
                if (src != R_NONE) begin
                    state_d = S_FLUSH;
                    flush_d = 1'b1;
                    if ((src != R_TRAP) &&
                        !is_aligned(MAX_XLEN'(redir_tgt), MAX_XLEN'(ILEN_B))) begin
                        pc_d    = trap_vec;
                        misal_d = 1'b1;
                    end else begin
                        pc_d = redir_tgt;
                    end
                end else begin
                    state_d = S_RUN;
                    if (vld_q && fetch_rdy && !stall) begin
                        pc_d = pc_q + XLEN'(ILEN_B);
                    end
                end
            end
            default: state_d = S_BOOT;
        endcase
        vld_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_VEC;
            vld_q   <= 1'b0;
            flush_q <= 1'b0;
            misal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            vld_q   <= vld_d;
            flush_q <= flush_d;
            misal_q <= misal_d;
        end
    end

    assign pc_o     = pc_q;
    assign pc_vld_o = vld_q;
    assign flush_o  = flush_q;
    assign misal_o  = misal_q;

`ifdef PC_RAS_EN
    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk    (clk),
        .rst_n  (reset),
        .push_i (ras_push),
        .pop_i  (ras_pop),
        .data_i (ctl_pc + XLEN'(ILEN_B)),
        .top_o  (ras_top_o)
    );
`else
    logic unused_ras;
    assign unused_ras = ras_push ^ ras_pop;
    assign ras_top_o  = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: expected outputs queued at drive time, compared after each edge.
module tb_pc_gen;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ILEN_B = 4;
    localparam int unsigned DEPTH  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            stall, fetch_rdy, trap_en, jalr_en, jal_en, br_en, ras_push, ras_pop;
    logic [XLEN-1:0] trap_vec, jalr_tgt, ctl_pc, ctl_imm;
    logic [XLEN-1:0] pc_o, ras_top_o;
    logic            pc_vld_o, flush_o, misal_o;

    always #5 clk = ~clk;

    pc_gen #(
        .XLEN      (XLEN),
        .RESET_VEC ('0),
        .ILEN_B    (ILEN_B),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .fetch_rdy (fetch_rdy),
        .trap_en   (trap_en),
        .trap_vec  (trap_vec),
        .jalr_en   (jalr_en),
        .jalr_tgt  (jalr_tgt),
        .jal_en    (jal_en),
        .br_en     (br_en),
        .ctl_pc    (ctl_pc),
        .ctl_imm   (ctl_imm),
        .ras_push  (ras_push),
        .ras_pop   (ras_pop),
        .pc_o      (pc_o),
        .pc_vld_o  (pc_vld_o),
        .flush_o   (flush_o),
        .misal_o   (misal_o),
        .ras_top_o (ras_top_o)
    );

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            vld;
        logic            flush;
        logic            misal;
        logic [XLEN-1:0] ras;
    } exp_t;

    exp_t            sb_q[$];
    int              checks   = 0;
    int              failures = 0;
    logic            m_boot, m_vld;
    logic [XLEN-1:0] m_pc;
    logic [XLEN-1:0] m_ras[$];

    task automatic check_eq(input string tag, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic clr();
        stall = 0; fetch_rdy = 1; trap_en = 0; jalr_en = 0; jal_en = 0; br_en = 0;
        ras_push = 0; ras_pop = 0; jalr_tgt = '0; ctl_pc = '0; ctl_imm = '0;
    endtask

    task automatic model_reset();
        m_boot = 1; m_vld = 0; m_pc = '0;
        m_ras.delete();
        sb_q.delete();
    endtask

    // Reference behaviour for the upcoming clock edge given the current inputs
    task automatic predict();
        exp_t            e;
        logic [XLEN-1:0] tgt;
        logic            redir, mis;
        e     = '0;
        tgt   = '0;
        redir = 1'b1;
        mis   = 1'b0;
        if (m_boot) begin
            m_boot = 0;
            m_vld  = 1;
        end else begin
            if (trap_en)              tgt = trap_vec;
            else if (jalr_en)         tgt = jalr_tgt & ~32'h1;
            else if (jal_en || br_en) tgt = ctl_pc + ctl_imm;
            else                      redir = 1'b0;
            if (redir && !trap_en && (tgt % ILEN_B) != 0) begin
                mis = 1'b1;
                tgt = trap_vec;
            end
            if (redir) begin
                m_pc  = tgt;
                m_vld = 0;
            end else begin
                if (m_vld && fetch_rdy && !stall) m_pc = m_pc + ILEN_B;
                m_vld = 1;
            end
            e.flush = redir;
            e.misal = mis;
        end
`ifdef PC_RAS_EN
        if (ras_push && ras_pop && m_ras.size() > 0) begin
            m_ras[m_ras.size()-1] = ctl_pc + ILEN_B;
        end else if (ras_push) begin
            m_ras.push_back(ctl_pc + ILEN_B);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end else if (ras_pop && m_ras.size() > 0) begin
            void'(m_ras.pop_back());
        end
        e.ras = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : '0;
`else
        e.ras = '0;
`endif
        e.pc  = m_pc;
        e.vld = m_vld;
        sb_q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        predict();
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq("pc", pc_o, e.pc);
            check_eq("vld", 32'(pc_vld_o), 32'(e.vld));
            check_eq("flush", 32'(flush_o), 32'(e.flush));
            check_eq("misal", 32'(misal_o), 32'(e.misal));
            check_eq("ras", ras_top_o, e.ras);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_pc"}, pc_o, 32'h0);
        check_eq({tag, "_vld"}, 32'(pc_vld_o), 32'd0);
        check_eq({tag, "_flush"}, 32'(flush_o), 32'd0);
        check_eq({tag, "_misal"}, 32'(misal_o), 32'd0);
        check_eq({tag, "_ras"}, ras_top_o, 32'h0);
    endtask

    initial begin
        reset = 0;
        trap_vec = '0;
        clr();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset = 1;
        #1;
        check_eq("boot_vld", 32'(pc_vld_o), 32'd0);

        repeat (3) step();
        check_eq("seq_8", pc_o, 32'h8);
        repeat (2) step();

        stall = 1;
        repeat (3) step();
        check_eq("stall_hold", pc_o, 32'h10);
        stall = 0;
        step();
        check_eq("stall_rel", pc_o, 32'h14);

        trap_en = 1; trap_vec = 32'h10;
        step();
        clr();
        fetch_rdy = 0;
        repeat (3) step();
        check_eq("rdy_hold", pc_o, 32'h10);
        fetch_rdy = 1;
        step();
        check_eq("rdy_rel", pc_o, 32'h14);

        br_en = 1; ctl_pc = 32'h20; ctl_imm = 32'h10;
        step();
        check_eq("br_pc", pc_o, 32'h30);
        check_eq("br_flush", 32'(flush_o), 32'd1);
        check_eq("br_vld", 32'(pc_vld_o), 32'd0);
        clr();
        repeat (2) step();

        jalr_en = 1; jalr_tgt = 32'h101;
        step();
        check_eq("jalr_pc", pc_o, 32'h100);
        clr();

        jal_en = 1; ctl_pc = 32'h40; ctl_imm = 32'h6; trap_vec = 32'h200;
        step();
        check_eq("misal_pc", pc_o, 32'h200);
        check_eq("misal_flag", 32'(misal_o), 32'd1);
        clr();
        step();

        trap_en = 1; jal_en = 1; br_en = 1; trap_vec = 32'h300; ctl_pc = 32'h40; ctl_imm = 32'h10;
        step();
        check_eq("prio_trap", pc_o, 32'h300);
        clr();

        br_en = 1; ctl_pc = 32'h80;
        step();
        clr();
        jalr_en = 1; jalr_tgt = 32'h90;
        step();
        check_eq("reflush_pc", pc_o, 32'h90);
        clr();
        step();

        trap_en = 1; trap_vec = 32'hFFFF_FFF8;
        step();
        clr();
        repeat (3) step();
        check_eq("wrap_pc", pc_o, 32'h0);

        for (int i = 0; i < 5; i++) begin
            ras_push = 1; ctl_pc = 32'h1000 + 32'(i * 16);
            step();
        end
        clr();
`ifdef PC_RAS_EN
        check_eq("ras_full_top", ras_top_o, 32'h1044);
`endif
        for (int i = 0; i < 5; i++) begin
            ras_pop = 1;
            step();
        end
        clr();
        check_eq("ras_empty_top", ras_top_o, 32'h0);

        br_en = 1; ctl_pc = 32'h500;
        step();
        clr();
        reset = 0;
        #1;
        check_reset_vals("midrst");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1;

        for (int n = 0; n < 300; n++) begin
            int r;
            r         = int'($urandom_range(0, 15));
            trap_en   = (r == 0);
            jalr_en   = (r == 1) || (r == 5);
            jal_en    = (r == 2) || (r == 5);
            br_en     = (r == 3) || (r == 4);
            stall     = ($urandom_range(0, 3) == 0);
            fetch_rdy = ($urandom_range(0, 3) != 0);
            trap_vec  = $urandom & ~32'h3;
            jalr_tgt  = $urandom & ~32'h2;
            if ($urandom_range(0, 5) == 0) jalr_tgt = $urandom;
            ctl_pc    = $urandom & ~32'h3;
            ctl_imm   = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & ~32'h3);
            ras_push  = ($urandom_range(0, 3) == 0);
            ras_pop   = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
